// File: rtl/i2c_target_regs.sv
// I2C target with a small register file: oversampled SCL/SDA, START/STOP decode,
// 7-bit address match, pointer byte then auto-incrementing data writes or reads.
module i2c_target_regs #(
    parameter logic [6:0] TGT_ADDR = 7'h3C,
    parameter int         NREGS    = 8,
    parameter int         FILTER   = 3,
    localparam int        PW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          wb_clk_i,
    input  logic          arst_i,
    input  logic          scl_pad_i,
    output logic          scl_pad_o,
    output logic          scl_padoen_o,
    input  logic          sda_pad_i,
    output logic          sda_pad_o,
    output logic          sda_padoen_o,
    input  logic [PW-1:0] reg_rd_addr,
    output logic [7:0]    reg_rd_data,
    output logic          wr_stb,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          busy
);

    localparam int FW = (FILTER > 1) ? $clog2(FILTER) + 1 : 1;

    typedef enum logic [3:0] {
        IDLE, ADDR, A_ACK, PTR, P_ACK, WDATA, W_ACK, RDATA, M_ACK
    } state_t;

    logic [1:0]    scl_s_q, sda_s_q;
    logic [FW-1:0] scl_cnt_q, sda_cnt_q;
    logic          scl_f_q, sda_f_q, scl_fd_q, sda_fd_q;

    state_t        state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] ptr_q, ptr_d, ptr_inc;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_stb_q, wr_stb_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          reg_we;
    logic [7:0]    regs_q [NREGS];

    logic       scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
    logic [7:0] byte_in;

    // Synchronizer, glitch filter and edge-delay registers; idle bus level is 1
    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            scl_s_q   <= 2'b11;
            sda_s_q   <= 2'b11;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_fd_q  <= 1'b1;
            sda_fd_q  <= 1'b1;
        end else begin
            scl_s_q  <= {scl_s_q[0], scl_pad_i};
            sda_s_q  <= {sda_s_q[0], sda_pad_i};
            scl_fd_q <= scl_f_q;
            sda_fd_q <= sda_f_q;
            if (scl_s_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FW'(FILTER - 1)) begin
                scl_f_q   <= scl_s_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + FW'(1);
            end
            if (sda_s_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FW'(FILTER - 1)) begin
                sda_f_q   <= sda_s_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + FW'(1);
            end
        end
    end

    assign scl_rise  = scl_f_q & ~scl_fd_q;
    assign scl_fall  = ~scl_f_q & scl_fd_q;
    assign sda_rise  = sda_f_q & ~sda_fd_q;
    assign sda_fall  = ~sda_f_q & sda_fd_q;
    assign start_det = sda_fall & scl_f_q;
    assign stop_det  = sda_rise & scl_f_q;
    assign byte_in   = {shift_q[6:0], sda_f_q};
    assign ptr_inc   = ptr_q + PW'(1);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        reg_we    = 1'b0;
        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = '0;
            busy_d    = 1'b1;
            sda_oe_d  = 1'b1;
        end else if (stop_det) begin
            state_d  = IDLE;
            busy_d   = 1'b0;
            sda_oe_d = 1'b1;
        end else begin
            case (state_q)
                ADDR, PTR, WDATA: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (state_q)
                                ADDR: state_d = (byte_in[7:1] == TGT_ADDR) ? A_ACK : IDLE;
                                PTR: begin
                                    ptr_d   = byte_in[PW-1:0];
                                    state_d = P_ACK;
                                end
                                default: begin
                                    reg_we    = 1'b1;
                                    wr_stb_d  = 1'b1;
                                    wr_addr_d = ptr_q;
                                    wr_data_d = byte_in;
                                    ptr_d     = ptr_inc;
                                    state_d   = W_ACK;
                                end
                            endcase
                        end
                    end
                end
                // The first fall in an ACK state starts the ACK, the second one ends it
                A_ACK, P_ACK, W_ACK: begin
                    if (scl_fall) begin
                        if (sda_oe_q) begin
                            sda_oe_d = 1'b0;
                        end else begin
                            bit_cnt_d = '0;
                            if (state_q == A_ACK && shift_q[0]) begin
                                state_d  = RDATA;
                                sda_oe_d = regs_q[ptr_q][7];
                                shift_d  = {regs_q[ptr_q][6:0], 1'b0};
                            end else begin
                                state_d  = (state_q == A_ACK) ? PTR : WDATA;
                                sda_oe_d = 1'b1;
                            end
                        end
                    end
                end
                RDATA: begin
                    if (scl_fall) begin
                        sda_oe_d = shift_q[7];
                        shift_d  = {shift_q[6:0], 1'b0};
                    end
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = M_ACK;
                    end
                end
                M_ACK: begin
                    if (scl_fall) sda_oe_d = 1'b1;
                    if (scl_rise) begin
                        ptr_d     = ptr_inc;
                        bit_cnt_d = '0;
                        if (sda_f_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d = RDATA;
                            shift_d = regs_q[ptr_inc];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or negedge arst_i) begin
        if (!arst_i) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b1;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            if (reg_we) regs_q[ptr_q] <= byte_in;
        end
    end

    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oe_q;
    assign reg_rd_data  = regs_q[reg_rd_addr];
    assign wr_stb       = wr_stb_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master, register model and
// write/read scoreboard queues.
module tb_i2c_target_regs;

    localparam int H = 10;

    logic       clk = 1'b0;
    logic       arst_i, scl_m, sda_m;
    logic [2:0] reg_rd_addr;
    logic       scl_pad_i, scl_pad_o, scl_padoen_o;
    logic       sda_pad_i, sda_pad_o, sda_padoen_o;
    logic [7:0] reg_rd_data, wr_data;
    logic [2:0] wr_addr;
    logic       wr_stb, busy;

    always #5 clk = ~clk;

    assign scl_pad_i = scl_m & (scl_padoen_o ? 1'b1 : scl_pad_o);
    assign sda_pad_i = sda_m & (sda_padoen_o ? 1'b1 : sda_pad_o);

    i2c_target_regs #(.TGT_ADDR(7'h3C), .NREGS(8), .FILTER(3)) dut (
        .wb_clk_i     (clk),
        .arst_i       (arst_i),
        .scl_pad_i    (scl_pad_i),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_i    (sda_pad_i),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .reg_rd_addr  (reg_rd_addr),
        .reg_rd_data  (reg_rd_data),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .busy         (busy)
    );

    int          checks = 0;
    int          fails  = 0;
    logic [10:0] obs [64];
    int          obs_n     = 0;
    int          pull_cnt  = 0;
    int          busy_rise = 0;
    logic        busy_prev = 1'b0;
    logic [7:0]  model [8];
    logic [10:0] wq [$];
    logic [7:0]  rq [$];
    int          rd_idx = 0;

    // Observed write strobes, SDA pulls and busy rises
    always @(negedge clk) begin
        if (arst_i && wr_stb) begin
            if (obs_n < 64) obs[obs_n] <= {wr_addr, wr_data};
            obs_n <= obs_n + 1;
        end
        if (!sda_padoen_o) pull_cnt <= pull_cnt + 1;
        busy_prev <= busy;
        if (busy && !busy_prev) busy_rise <= busy_rise + 1;
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: observed no finish, expected finish within 60000 cycles");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_io(input logic b, output logic r);
        sda_m = b;
        wait_n(H);
        scl_m = 1'b1;
        wait_n(2 * H);
        r = sda_pad_i;
        scl_m = 1'b0;
        wait_n(H);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_n(H);
        scl_m = 1'b1; wait_n(H);
        sda_m = 1'b0; wait_n(H);
        scl_m = 1'b0; wait_n(H);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_n(H);
        scl_m = 1'b1; wait_n(H);
        sda_m = 1'b1; wait_n(2 * H);
    endtask

    task automatic send(input logic [7:0] b, input logic exp_ack, input string tag);
        logic r, a;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, a);
        chk(tag, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic send_data(input logic [2:0] a, input logic [7:0] d, input string tag);
        wq.push_back({a, d});
        model[a] = d;
        send(d, 1'b0, tag);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            d[i] = r;
        end
        bit_io(nack, r);
    endtask

    task automatic check_writes(input string tag);
        logic [10:0] e;
        chk({tag, "_count"}, obs_n, rd_idx + wq.size());
        while (wq.size() > 0) begin
            e = wq.pop_front();
            chk(tag, {21'd0, obs[rd_idx % 64]}, {21'd0, e});
            rd_idx++;
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            reg_rd_addr = 3'(i);
            #1;
            chk(tag, {24'd0, reg_rd_data}, {24'd0, model[i]});
        end
    endtask

    initial begin
        logic [7:0] d;
        int         p, b;
        arst_i = 1'b0;
        scl_m  = 1'b1;
        sda_m  = 1'b1;
        reg_rd_addr = '0;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        wait_n(3);
        chk("rst_sda_oe", {31'd0, sda_padoen_o}, 32'd1);
        chk("rst_scl_oe", {31'd0, scl_padoen_o}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
        chk("rst_wr_addr", {29'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        check_regs("rst_reg");
        arst_i = 1'b1;
        wait_n(5);

        // Write burst at pointer 2
        i2c_start();
        chk("burst_busy", {31'd0, busy}, 32'd1);
        send(8'h78, 1'b0, "burst_addr_ack");
        send(8'h02, 1'b0, "burst_ptr_ack");
        send_data(3'd2, 8'hA5, "burst_d0_ack");
        send_data(3'd3, 8'h5A, "burst_d1_ack");
        i2c_stop();
        chk("burst_stop_busy", {31'd0, busy}, 32'd0);
        check_writes("burst_wr");
        check_regs("burst_reg");

        // Combined write-pointer / repeated START / read
        i2c_start();
        send(8'h78, 1'b0, "rd_addr_w_ack");
        send(8'h02, 1'b0, "rd_ptr_ack");
        i2c_start();
        send(8'h79, 1'b0, "rd_addr_r_ack");
        rq.push_back(8'hA5);
        rd_byte(1'b0, d);
        chk("rd_byte0", {24'd0, d}, {24'd0, rq.pop_front()});
        rq.push_back(8'h5A);
        rd_byte(1'b1, d);
        chk("rd_byte1", {24'd0, d}, {24'd0, rq.pop_front()});
        p = pull_cnt;
        rd_byte(1'b1, d);
        chk("rd_after_nack", {24'd0, d}, 32'hFF);
        chk("rd_after_nack_pull", pull_cnt, p);
        i2c_stop();
        chk("rd_stop_busy", {31'd0, busy}, 32'd0);
        check_writes("rd_wr");

        // Address miss
        p = pull_cnt;
        i2c_start();
        send(8'h7A, 1'b1, "miss_addr_nack");
        send(8'h00, 1'b1, "miss_b1_nack");
        send(8'h11, 1'b1, "miss_b2_nack");
        i2c_stop();
        chk("miss_pull", pull_cnt, p);
        check_writes("miss_wr");
        check_regs("miss_reg");

        // Pointer wrap and oversize pointer byte
        i2c_start();
        send(8'h78, 1'b0, "wrap_addr_ack");
        send(8'h07, 1'b0, "wrap_ptr_ack");
        send_data(3'd7, 8'h01, "wrap_d0_ack");
        send_data(3'd0, 8'h02, "wrap_d1_ack");
        send_data(3'd1, 8'h03, "wrap_d2_ack");
        i2c_stop();
        check_writes("wrap_wr");
        check_regs("wrap_reg");
        i2c_start();
        send(8'h78, 1'b0, "ptr0f_addr_ack");
        send(8'h0F, 1'b0, "ptr0f_ptr_ack");
        send_data(3'd7, 8'h44, "ptr0f_d0_ack");
        i2c_stop();
        check_writes("ptr0f_wr");
        check_regs("ptr0f_reg");

        // Short SDA glitch while SCL is high
        b = busy_rise;
        sda_m = 1'b0;
        wait_n(2);
        sda_m = 1'b1;
        wait_n(20);
        chk("glitch_busy", {31'd0, busy}, 32'd0);
        chk("glitch_no_start", busy_rise, b);

        // Reset while the target drives a 0 data bit (regs[0]=02, MSB 0)
        i2c_start();
        send(8'h79, 1'b0, "mid_addr_ack");
        chk("mid_driving", {31'd0, sda_padoen_o}, 32'd0);
        arst_i = 1'b0;
        #1;
        chk("mid_rst_release", {31'd0, sda_padoen_o}, 32'd1);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_n(5);
        arst_i = 1'b1;
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
        wait_n(5);
        i2c_start();
        send(8'h78, 1'b0, "post_addr_ack");
        send(8'h03, 1'b0, "post_ptr_ack");
        send_data(3'd3, 8'h9C, "post_d0_ack");
        i2c_stop();
        check_writes("post_wr");
        check_regs("post_reg");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
